// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB types and constants for the arbiter and master mux
//
// Purpose : transfer/burst/response encodings and master-count constants
//           common to ahb_arbiter and ahb_master_mux.
// Ports   : none (package).
package ahb_pkg;

  localparam int AHB_NM = 4;  // number of bus masters
  localparam int AHB_MW = 2;  // width of the master index

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no data phase.
  function automatic logic htrans_has_dphase(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mux_stats.sv
// rtl/ahb_mux_stats.sv - per-master saturating OKAY/ERROR transfer counter bank
//
// Purpose : counts completed data phases per master, saturating at all-ones.
// Ports   : clk_i, resetn_i (sync, active-low)
//           clr_i       - zero every counter; wins over a same-edge increment
//           done_i      - a data phase completes on this edge
//           err_i       - completing response is ERROR (else OKAY)
//           idx_i       - master owning the completing data phase
//           xfer_cnt_o  - packed OKAY counts, master i in slice i
//           err_cnt_o   - packed ERROR counts, master i in slice i
module ahb_mux_stats #(
  parameter int NM    = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = 2
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                clr_i,
  input  logic                done_i,
  input  logic                err_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [NM*CNT_W-1:0] xfer_cnt_o,
  output logic [NM*CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] xfer_q [NM];
  logic [CNT_W-1:0] xfer_d [NM];
  logic [CNT_W-1:0] err_q  [NM];
  logic [CNT_W-1:0] err_d  [NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      xfer_d[i] = xfer_q[i];
      err_d[i]  = err_q[i];
      if (clr_i) begin
        xfer_d[i] = '0;
        err_d[i]  = '0;
      end else if (done_i && (int'(idx_i) == i)) begin
        if (err_i) begin
          if (err_q[i] != '1) err_d[i] = err_q[i] + ONE;
        end else begin
          if (xfer_q[i] != '1) xfer_d[i] = xfer_q[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NM; i++) begin
        xfer_q[i] <= '0;
        err_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        xfer_q[i] <= xfer_d[i];
        err_q[i]  <= err_d[i];
      end
    end
  end

  for (genvar g = 0; g < NM; g++) begin : g_out
    assign xfer_cnt_o[g*CNT_W +: CNT_W] = xfer_q[g];
    assign err_cnt_o[g*CNT_W +: CNT_W]  = err_q[g];
  end

endmodule

// File: rtl/ahb_master_mux.sv
// rtl/ahb_master_mux.sv - AHB master-to-slave address/control and write-data mux
//
// Purpose : forwards the granted master's address phase combinationally and
//           steers Hwdata from the master that owns the pipelined data phase.
// Ports   : Hclk, Hresetn (sync, active-low)
//           Hmaster, Hready, Hresp           - arbiter index, slave handshake
//           Haddr_m/Htrans_m/Hwrite_m/Hsize_m/Hburst_m/Hwdata_m - packed
//                                              per-master buses, master i in slice i
//           Haddr/Htrans/Hwrite/Hsize/Hburst - selected address phase
//           Hwdata, Hmaster_d, dphase_valid  - data-phase data and owner
//           stats_clr, xfer_cnt, err_cnt     - only with AHB_MUX_STATS_EN
// Config  : `define AHB_MUX_STATS_EN adds the per-master transfer counters.
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter int NM     = AHB_NM,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  input  logic [AHB_MW-1:0]    Hmaster,
  input  logic                 Hready,
  input  logic                 Hresp,
  input  logic [NM*ADDR_W-1:0] Haddr_m,
  input  logic [NM*2-1:0]      Htrans_m,
  input  logic [NM-1:0]        Hwrite_m,
  input  logic [NM*3-1:0]      Hsize_m,
  input  logic [NM*3-1:0]      Hburst_m,
  input  logic [NM*DATA_W-1:0] Hwdata_m,
  output logic [ADDR_W-1:0]    Haddr,
  output logic [1:0]           Htrans,
  output logic                 Hwrite,
  output logic [2:0]           Hsize,
  output logic [2:0]           Hburst,
  output logic [DATA_W-1:0]    Hwdata,
  output logic [AHB_MW-1:0]    Hmaster_d,
`ifdef AHB_MUX_STATS_EN
  input  logic                 stats_clr,
  output logic [NM*CNT_W-1:0]  xfer_cnt,
  output logic [NM*CNT_W-1:0]  err_cnt,
`endif
  output logic                 dphase_valid
);

  // Address phase: purely combinational from the granted master.
  always_comb begin
    Haddr  = Haddr_m[int'(Hmaster)*ADDR_W +: ADDR_W];
    Htrans = Htrans_m[int'(Hmaster)*2 +: 2];
    Hwrite = Hwrite_m[Hmaster];
    Hsize  = Hsize_m[int'(Hmaster)*3 +: 3];
    Hburst = Hburst_m[int'(Hmaster)*3 +: 3];
    // Slaves must see no transfer request while the bus is in reset.
    if (!Hresetn) Htrans = HTRANS_IDLE;
  end

  // Data-phase tracking: capture the address phase only when the previous
  // transfer completes, so wait states hold the owner and its write data.
  logic [AHB_MW-1:0] owner_q, owner_d;
  logic              valid_q, valid_d;
  logic              write_q, write_d;

  always_comb begin
    owner_d = owner_q;
    valid_d = valid_q;
    write_d = write_q;
    if (Hready) begin
      owner_d = Hmaster;
      valid_d = htrans_has_dphase(Htrans);
      write_d = Hwrite;
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      owner_q <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      valid_q <= valid_d;
      write_q <= write_d;
    end
  end

  assign Hmaster_d    = owner_q;
  assign dphase_valid = valid_q;
  assign Hwdata       = (valid_q && write_q) ? Hwdata_m[int'(owner_q)*DATA_W +: DATA_W]
                                             : '0;

`ifdef AHB_MUX_STATS_EN
  // A two-cycle ERROR has Hready low on its first cycle, so qualifying with
  // Hready counts each transfer exactly once.
  ahb_mux_stats #(
    .NM    (NM),
    .CNT_W (CNT_W),
    .IDX_W (AHB_MW)
  ) u_stats (
    .clk_i      (Hclk),
    .resetn_i   (Hresetn),
    .clr_i      (stats_clr),
    .done_i     (valid_q && Hready),
    .err_i      (Hresp),
    .idx_i      (owner_q),
    .xfer_cnt_o (xfer_cnt),
    .err_cnt_o  (err_cnt)
  );
`else
  logic unused_nostats;
  assign unused_nostats = ^{Hresp, 32'(CNT_W)};
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// tb/tb_ahb_master_mux.sv - self-checking bench for ahb_master_mux
//
// Purpose : directed scenarios plus randomized traffic against a
//           transaction-level reference model of the mux.
// Ports   : none (top-level bench). Honours AHB_MUX_STATS_EN.
module tb_ahb_master_mux;
  import ahb_pkg::*;

  localparam int NM     = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                 Hclk = 1'b0;
  logic                 Hresetn, Hready, Hresp;
  logic [1:0]           Hmaster;
  logic [NM*ADDR_W-1:0] Haddr_m;
  logic [NM*2-1:0]      Htrans_m;
  logic [NM-1:0]        Hwrite_m;
  logic [NM*3-1:0]      Hsize_m, Hburst_m;
  logic [NM*DATA_W-1:0] Hwdata_m;
  logic [ADDR_W-1:0]    Haddr;
  logic [1:0]           Htrans;
  logic                 Hwrite;
  logic [2:0]           Hsize, Hburst;
  logic [DATA_W-1:0]    Hwdata;
  logic [1:0]           Hmaster_d;
  logic                 dphase_valid;
  logic                 stats_clr;
`ifdef AHB_MUX_STATS_EN
  logic [NM*CNT_W-1:0]  xfer_cnt, err_cnt;
`endif

  always #5 Hclk = ~Hclk;

  ahb_master_mux #(.NM(NM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hmaster(Hmaster), .Hready(Hready), .Hresp(Hresp),
    .Haddr_m(Haddr_m), .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m), .Hsize_m(Hsize_m),
    .Hburst_m(Hburst_m), .Hwdata_m(Hwdata_m), .Haddr(Haddr), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Hwdata(Hwdata),
    .Hmaster_d(Hmaster_d),
`ifdef AHB_MUX_STATS_EN
    .stats_clr(stats_clr), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt),
`endif
    .dphase_valid(dphase_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the last accepted address phase and counter totals.
  logic [1:0] m_owner;
  logic       m_valid, m_write;
  int         m_xfer [NM];
  int         m_errc [NM];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_m(input int i, input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    Htrans_m[i*2 +: 2]            = t;
    Hwrite_m[i]                   = w;
    Haddr_m[i*ADDR_W +: ADDR_W]   = a;
    Hwdata_m[i*DATA_W +: DATA_W]  = d;
  endtask

  task automatic model_reset();
    m_owner = 2'd0;
    m_valid = 1'b0;
    m_write = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_xfer[i] = 0;
      m_errc[i] = 0;
    end
  endtask

  // Sampled on the falling edge, well away from the register update.
  task automatic check_all();
    int s;
    logic [DATA_W-1:0] exp_wd;
    @(negedge Hclk);
    s = int'(Hmaster);
    check_eq("haddr",  Haddr,  Haddr_m[s*ADDR_W +: ADDR_W]);
    check_eq("htrans", Htrans, Hresetn ? Htrans_m[s*2 +: 2] : 2'b00);
    check_eq("hwrite", Hwrite, Hwrite_m[s]);
    check_eq("hsize",  Hsize,  Hsize_m[s*3 +: 3]);
    check_eq("hburst", Hburst, Hburst_m[s*3 +: 3]);
    exp_wd = (m_valid && m_write) ? Hwdata_m[int'(m_owner)*DATA_W +: DATA_W] : '0;
    check_eq("hwdata", Hwdata, exp_wd);
    check_eq("hmaster_d", Hmaster_d, m_owner);
    check_eq("dphase_valid", dphase_valid, m_valid);
`ifdef AHB_MUX_STATS_EN
    for (int i = 0; i < NM; i++) begin
      check_eq($sformatf("xfer_cnt%0d", i), xfer_cnt[i*CNT_W +: CNT_W], m_xfer[i]);
      check_eq($sformatf("err_cnt%0d", i),  err_cnt[i*CNT_W +: CNT_W],  m_errc[i]);
    end
`endif
  endtask

  // Advance one edge and apply the bus rules to the model from the stimulus.
  task automatic clock_edge();
    int s;
    @(posedge Hclk);
    s = int'(Hmaster);
    if (!Hresetn) begin
      model_reset();
    end else begin
`ifdef AHB_MUX_STATS_EN
      if (stats_clr) begin
        for (int i = 0; i < NM; i++) begin
          m_xfer[i] = 0;
          m_errc[i] = 0;
        end
      end else if (m_valid && Hready) begin
        if (Hresp) m_errc[m_owner] = (m_errc[m_owner] < CMAX) ? m_errc[m_owner] + 1 : CMAX;
        else       m_xfer[m_owner] = (m_xfer[m_owner] < CMAX) ? m_xfer[m_owner] + 1 : CMAX;
      end
`endif
      if (Hready) begin
        m_owner = Hmaster;
        m_valid = Htrans_m[s*2 + 1];
        m_write = Hwrite_m[s];
      end
    end
    #1;
  endtask

  task automatic all_idle();
    for (int i = 0; i < NM; i++) set_m(i, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    model_reset();
    Hresetn = 1'b0; Hready = 1'b1; Hresp = 1'b0; stats_clr = 1'b0; Hmaster = 2'd1;
    Hsize_m = 12'h492; Hburst_m = 12'hAC1;
    for (int i = 0; i < NM; i++) set_m(i, 2'b10, 1'b1, 32'h100 * i, 32'h5000 + i);

    // Reset state, with masters requesting so the IDLE forcing is visible.
    repeat (2) begin
      check_all();
      check_eq("rst_htrans", Htrans, 2'b00);
      check_eq("rst_hmaster_d", Hmaster_d, 2'd0);
      check_eq("rst_dvalid", dphase_valid, 1'b0);
      check_eq("rst_hwdata", Hwdata, 32'h0);
      clock_edge();
    end
    Hresetn = 1'b1;
    all_idle();

    // Single write, no wait.
    Hmaster = 2'd2;
    set_m(2, 2'b10, 1'b1, 32'h1000, 32'hA5A5_A5A5);
    check_all();
    check_eq("single_haddr", Haddr, 32'h1000);
    clock_edge();
    set_m(2, 2'b00, 1'b0, 32'h1004, 32'hA5A5_A5A5);
    check_all();
    check_eq("single_owner", Hmaster_d, 2'd2);
    check_eq("single_hwdata", Hwdata, 32'hA5A5_A5A5);
    clock_edge();

    // Handover overlap: master 1 data phase alongside master 3 address phase.
    Hmaster = 2'd1;
    set_m(1, 2'b10, 1'b1, 32'h20, 32'h1111_2222);
    check_all();
    clock_edge();
    Hmaster = 2'd3;
    set_m(3, 2'b10, 1'b0, 32'h40, 32'h0);
    set_m(1, 2'b00, 1'b0, 32'h24, 32'h1111_2222);
    check_all();
    check_eq("ho_haddr", Haddr, 32'h40);
    check_eq("ho_hwdata", Hwdata, 32'h1111_2222);
    check_eq("ho_owner", Hmaster_d, 2'd1);
    clock_edge();

    // Read data phase of master 3, then an idle data phase.
    set_m(3, 2'b00, 1'b0, 32'h44, 32'hFFFF_0000);
    check_all();
    check_eq("read_dvalid", dphase_valid, 1'b1);
    check_eq("read_hwdata", Hwdata, 32'h0);
    clock_edge();
    check_all();
    check_eq("idle_dvalid", dphase_valid, 1'b0);
    check_eq("idle_hwdata", Hwdata, 32'h0);
    clock_edge();

    // Wait states during master 0's write while the grant moves to master 2.
    Hmaster = 2'd0;
    set_m(0, 2'b10, 1'b1, 32'h80, 32'hDEAD_BEEF);
    check_all();
    clock_edge();
    Hmaster = 2'd2;
    set_m(2, 2'b10, 1'b1, 32'h90, 32'h2222_3333);
    set_m(0, 2'b00, 1'b0, 32'h84, 32'hDEAD_BEEF);
    Hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_all();
      check_eq("ws_owner", Hmaster_d, 2'd0);
      check_eq("ws_hwdata", Hwdata, 32'hDEAD_BEEF);
      clock_edge();
    end
    Hready = 1'b1;
    check_all();
    check_eq("ws_last_hwdata", Hwdata, 32'hDEAD_BEEF);
    clock_edge();
    set_m(2, 2'b00, 1'b0, 32'h94, 32'h2222_3333);
    check_all();
    check_eq("ws_next_owner", Hmaster_d, 2'd2);
    check_eq("ws_next_hwdata", Hwdata, 32'h2222_3333);
    clock_edge();
    all_idle();

`ifdef AHB_MUX_STATS_EN
    // Statistics: five OKAY and one two-cycle ERROR on master 1.
    stats_clr = 1'b1;
    check_all();
    clock_edge();
    stats_clr = 1'b0;
    Hmaster = 2'd1;
    set_m(1, 2'b10, 1'b1, 32'h200, 32'h77);
    for (int k = 0; k < 5; k++) begin
      check_all();
      clock_edge();
    end
    set_m(1, 2'b00, 1'b0, 32'h214, 32'h77);
    check_all();
    clock_edge();
    set_m(1, 2'b10, 1'b1, 32'h300, 32'h88);
    check_all();
    clock_edge();
    set_m(1, 2'b00, 1'b0, 32'h304, 32'h88);
    Hready = 1'b0; Hresp = 1'b1;
    check_all();
    clock_edge();
    Hready = 1'b1;
    check_all();
    clock_edge();
    Hresp = 1'b0;
    check_all();
    check_eq("stats_xfer1", xfer_cnt[1*CNT_W +: CNT_W], 4'd5);
    check_eq("stats_err1", err_cnt[1*CNT_W +: CNT_W], 4'd1);
    set_m(1, 2'b10, 1'b1, 32'h400, 32'h99);
    repeat (21) begin
      check_all();
      clock_edge();
    end
    check_all();
    check_eq("stats_sat", xfer_cnt[1*CNT_W +: CNT_W], 4'd15);
    stats_clr = 1'b1;
    clock_edge();
    stats_clr = 1'b0;
    all_idle();
    check_all();
    check_eq("stats_clr_xfer", xfer_cnt[1*CNT_W +: CNT_W], 4'd0);
    check_eq("stats_clr_err", err_cnt[1*CNT_W +: CNT_W], 4'd0);
    clock_edge();
`endif

    // Reset in the middle of an INCR4 write burst from master 3.
    Hmaster = 2'd3;
    Hburst_m[3*3 +: 3] = HBURST_INCR4;
    set_m(3, 2'b10, 1'b1, 32'h100, 32'h33);
    check_all();
    clock_edge();
    set_m(3, 2'b11, 1'b1, 32'h104, 32'h34);
    check_all();
    clock_edge();
    Hresetn = 1'b0;
    set_m(3, 2'b11, 1'b1, 32'h108, 32'h35);
    check_all();
    check_eq("rstmid_htrans", Htrans, 2'b00);
    clock_edge();
    check_all();
    check_eq("rstmid_owner", Hmaster_d, 2'd0);
    check_eq("rstmid_dvalid", dphase_valid, 1'b0);
    check_eq("rstmid_hwdata", Hwdata, 32'h0);
    Hresetn = 1'b1;
    clock_edge();

    // Randomized traffic.
    repeat (400) begin
      Hmaster   = 2'($urandom_range(0, 3));
      Hready    = ($urandom_range(0, 3) != 0);
      Hresp     = 1'($urandom_range(0, 1));
      Hresetn   = ($urandom_range(0, 49) != 0);
      stats_clr = ($urandom_range(0, 29) == 0);
      Hsize_m   = 12'($urandom);
      Hburst_m  = 12'($urandom);
      for (int i = 0; i < NM; i++)
        set_m(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      check_all();
      clock_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_master_mux.md
# ahb_master_mux

Address/control and write-data multiplexer between the four AHB masters and the shared slave bus. It sits directly downstream of `ahb_arbiter` and consumes its `Hmaster` index. It forwards the granted master's address-phase signals combinationally. It tracks the pipelined data phase so that `Hwdata` comes from the master that owned the previous address phase, not the current one.

## Interface
Parameters:
- `NM`, 4: number of masters. Fixed at 4 to match the 2-bit `Hmaster`.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `CNT_W`, 16: width of statistics counters (only with `AHB_MUX_STATS_EN`).

Ports (per-master buses packed; master i occupies slice i):
- `Hclk`  in  1  bus clock; single clock domain.
- `Hresetn`  in  1  synchronous, active-low reset, sampled on rising `Hclk`.
- `Hmaster`  in  2  address-phase owner from the arbiter.
- `Hready`  in  1  global transfer-done from the slave response mux.
- `Hresp`  in  1  slave response, 0 = OKAY, 1 = ERROR.
- `Haddr_m`  in  NM*ADDR_W  master addresses.
- `Htrans_m`  in  NM*2  master transfer types.
- `Hwrite_m`  in  NM  master write flags.
- `Hsize_m`  in  NM*3  master sizes.
- `Hburst_m`  in  NM*3  master burst types.
- `Hwdata_m`  in  NM*DATA_W  master write data.
- `Haddr`  out  ADDR_W  selected address.
- `Htrans`  out  2  selected transfer type.
- `Hwrite`  out  1  selected write flag.
- `Hsize`  out  3  selected size.
- `Hburst`  out  3  selected burst type.
- `Hwdata`  out  DATA_W  data-phase write data.
- `Hmaster_d`  out  2  data-phase owner.
- `dphase_valid`  out  1  a NONSEQ/SEQ data phase is in progress.
- `stats_clr`  in  1  synchronous clear of all counters (`AHB_MUX_STATS_EN` only).
- `xfer_cnt`  out  NM*CNT_W  per-master OKAY transfer counts (`AHB_MUX_STATS_EN` only).
- `err_cnt`  out  NM*CNT_W  per-master ERROR counts (`AHB_MUX_STATS_EN` only).

## Operation
- Address phase: all five address/control outputs are combinational from slice `Hmaster`. There is no register on this path.
- While `Hresetn` is low, `Htrans` is forced to IDLE (2'b00). All other address outputs still follow slice `Hmaster`.
- Data-phase tracking uses three registers: `Hmaster_d`, `dphase_valid` and `dphase_write`.
  - When `Hready`=1: `Hmaster_d` <= `Hmaster`, `dphase_valid` <= `Htrans`[1] (NONSEQ or SEQ), `dphase_write` <= `Hwrite`.
  - When `Hready`=0: all three hold, so the data phase is extended and the owner does not change.
- `Hwdata` = slice `Hmaster_d` of `Hwdata_m` when `dphase_valid` and `dphase_write` are both set. Otherwise it is 0.
- IDLE and BUSY address phases produce no data phase (`dphase_valid`=0 next cycle).
- Handover: when `Hmaster` changes, the old master keeps the data phase through `Hmaster_d` while the new master drives the address. Both can be active in the same cycle.
- Statistics (`AHB_MUX_STATS_EN`), evaluated on a rising edge with `dphase_valid`=1 and `Hready`=1:
  - `Hresp`=0 increments `xfer_cnt[Hmaster_d]`.
  - `Hresp`=1 increments `err_cnt[Hmaster_d]`.
  - Only the final cycle of a two-cycle ERROR response counts, so each transfer is counted once.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - `stats_clr`=1 zeroes all counters. If clear and increment occur on the same edge, clear wins.

## Timing
- Reset values: `Hmaster_d`=0, `dphase_valid`=0, `dphase_write`=0, `Hwdata`=0, all counters 0.
- Address path latency: 0 cycles (combinational).
- Data-phase owner latency: 1 `Hready`-qualified edge after the address phase.
- Reset asserted mid-transfer: on the next edge all registers return to reset values, and the in-flight data phase is dropped and not counted.
- Reset deasserted: the first address phase can be accepted on the first edge with `Hresetn`=1.
- `Hready` low for N cycles stretches the data phase by N cycles. `Hwdata` stays stable from the same master throughout.

## Configuration
- `AHB_MUX_STATS_EN` defined: the counter registers, `stats_clr`, `xfer_cnt` and `err_cnt` are present and behave as described in Operation.
- `AHB_MUX_STATS_EN` undefined: those three ports are absent, no counter flops are built, and all other behaviour is identical.

## Structure
- Shared `ahb_pkg`: `htrans_t` (IDLE/BUSY/NONSEQ/SEQ), `hburst_t`, `hresp_t`, and the constants `AHB_NM`=4 and `AHB_MW`=2. `ahb_arbiter` and this block share these definitions.
- One sub-module, `ahb_mux_stats`: per-master saturating counter bank with clear, instantiated under `AHB_MUX_STATS_EN`.

## Test plan
- Single write, no wait: `Hmaster`=2, master 2 drives NONSEQ write to 0x1000 with wdata 0xA5A5_A5A5 → `Haddr`=0x1000 the same cycle; next cycle `Hmaster_d`=2 and `Hwdata`=0xA5A5_A5A5.
- Handover overlap: master 1 does a write to 0x20, then the grant moves to master 3 doing NONSEQ to 0x40 → in that cycle `Haddr`=0x40 and `Hwdata`=master 1's data, with `Hmaster_d`=1.
- Wait states: `Hready`=0 for 3 cycles during master 0's write data phase while `Hmaster` changes to 2 → `Hmaster_d` stays 0 and `Hwdata` stays stable for 3 cycles.
- Idle/read suppression: IDLE or read address phase → next cycle `dphase_valid`/`Hwdata` = 0/0 and 1/0 respectively; no counter change for IDLE.
- Stats: master 1 completes 5 OKAY transfers and 1 two-cycle ERROR → `xfer_cnt[1]`=5 and `err_cnt[1]`=1. Then with CNT_W=4, 20 more transfers saturate at 15, and `stats_clr` together with a completing transfer leaves 0.
- Reset mid-burst: assert `Hresetn`=0 during an INCR4 write data phase → next edge `Hmaster_d`=0, `dphase_valid`=0 and `Hwdata`=0; `Htrans` reads IDLE while reset is low.
